// File: rtl/history_buf.sv
// Circular history buffer with a browse cursor: push stores the newest entry, browse walks the cursor older/newer.
// Optional macro HISTORY_BUF_NEXT_EN adds the browse_next port and newer-direction browsing.
module history_buf #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 5,
  parameter int OVERWRITE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       browse_prev,
`ifdef HISTORY_BUF_NEXT_EN
  input  logic                       browse_next,
`endif
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    cur;
  logic [LW-1:0]    count;
  logic             ovf_q;

  logic [PW-1:0]    oldest;
  logic [PW-1:0]    newest;
  logic [PW-1:0]    cur_older;
  logic             go_prev;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  // The oldest valid entry sits "count" slots behind the write pointer.
  always_comb begin
    int t;
    t = int'(wr_ptr) - int'(count);
    if (t < 0) t = t + DEPTH;
    oldest = PW'(t);
  end

  assign newest    = ptr_dec(wr_ptr);
  assign cur_older = (cur == oldest) ? newest : ptr_dec(cur);

`ifdef HISTORY_BUF_NEXT_EN
  logic [PW-1:0] cur_newer;
  logic          go_next;
  assign cur_newer = (cur == newest) ? oldest : ptr_inc(cur);
  // Opposing browse requests cancel each other.
  assign go_prev   = browse_prev & ~browse_next;
  assign go_next   = browse_next & ~browse_prev;
`else
  assign go_prev   = browse_prev;
`endif

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign overflow = ovf_q;
  assign data_out = empty ? '0 : mem[cur];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      cur    <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      cur    <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (push) begin
      ovf_q <= full;
      if (!full) begin
        mem[wr_ptr] <= data_in;
        cur         <= wr_ptr;
        wr_ptr      <= ptr_inc(wr_ptr);
        count       <= count + LW'(1);
      end else if (OVERWRITE != 0) begin
        // Slot at wr_ptr holds the oldest entry when full; replace it in place.
        mem[wr_ptr] <= data_in;
        cur         <= wr_ptr;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
    end else begin
      ovf_q <= 1'b0;
      if (!empty) begin
        if (go_prev) cur <= cur_older;
`ifdef HISTORY_BUF_NEXT_EN
        else if (go_next) cur <= cur_newer;
`endif
      end
    end
  end

endmodule

// File: tb/tb_history_buf.sv
// Directed bench for history_buf: vector table on an OVERWRITE=1 instance, hand sequences for the
// reject-when-full instance, newer-direction browsing (HISTORY_BUF_NEXT_EN) and the async reset pulse.
module tb_history_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_clear = 0, a_push = 0, a_prev = 0;
  logic [11:0] a_din = 0;
  logic [11:0] a_out;
  logic [2:0]  a_level;
  logic        a_full, a_empty, a_ovf;

  logic        b_clear = 0, b_push = 0, b_prev = 0;
  logic [11:0] b_din = 0;
  logic [11:0] b_out;
  logic [2:0]  b_level;
  logic        b_full, b_empty, b_ovf;

`ifdef HISTORY_BUF_NEXT_EN
  logic a_next = 0, b_next = 0;
`endif

  history_buf #(.WIDTH(12), .DEPTH(5), .OVERWRITE(1)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .push(a_push), .data_in(a_din),
    .browse_prev(a_prev),
`ifdef HISTORY_BUF_NEXT_EN
    .browse_next(a_next),
`endif
    .data_out(a_out), .level(a_level), .full(a_full), .empty(a_empty), .overflow(a_ovf)
  );

  history_buf #(.WIDTH(12), .DEPTH(5), .OVERWRITE(0)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .push(b_push), .data_in(b_din),
    .browse_prev(b_prev),
`ifdef HISTORY_BUF_NEXT_EN
    .browse_next(b_next),
`endif
    .data_out(b_out), .level(b_level), .full(b_full), .empty(b_empty), .overflow(b_ovf)
  );

  typedef struct {
    logic        clr, psh, prv;
    logic [11:0] din, eout;
    int          elvl;
    logic        eovf;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic clr, psh, prv, input logic [11:0] din, eout,
                     input int elvl, input logic eovf);
    tbl[n_vec].clr  = clr;
    tbl[n_vec].psh  = psh;
    tbl[n_vec].prv  = prv;
    tbl[n_vec].din  = din;
    tbl[n_vec].eout = eout;
    tbl[n_vec].elvl = elvl;
    tbl[n_vec].eovf = eovf;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full/empty are derived from the expected level with DEPTH=5.
  task automatic chk_a(input string tag, input logic [11:0] eout, input int elvl, input logic eovf);
    chk({tag, " a.out"},   32'(a_out),   32'(eout));
    chk({tag, " a.level"}, 32'(a_level), 32'(elvl));
    chk({tag, " a.full"},  32'(a_full),  32'(elvl == 5));
    chk({tag, " a.empty"}, 32'(a_empty), 32'(elvl == 0));
    chk({tag, " a.ovf"},   32'(a_ovf),   32'(eovf));
  endtask

  task automatic chk_b(input string tag, input logic [11:0] eout, input int elvl, input logic eovf);
    chk({tag, " b.out"},   32'(b_out),   32'(eout));
    chk({tag, " b.level"}, 32'(b_level), 32'(elvl));
    chk({tag, " b.full"},  32'(b_full),  32'(elvl == 5));
    chk({tag, " b.empty"}, 32'(b_empty), 32'(elvl == 0));
    chk({tag, " b.ovf"},   32'(b_ovf),   32'(eovf));
  endtask

  task automatic step_a(input logic clr, psh, prv, input logic [11:0] din);
    a_clear = clr; a_push = psh; a_prev = prv; a_din = din;
    @(posedge clk); #1;
    a_clear = 0; a_push = 0; a_prev = 0; a_din = 0;
  endtask

  task automatic step_b(input logic psh, prv, input logic [11:0] din);
    b_push = psh; b_prev = prv; b_din = din;
    @(posedge clk); #1;
    b_push = 0; b_prev = 0; b_din = 0;
  endtask

  initial begin
    add(0, 1, 0, 12'h011, 12'h011, 1, 0);
    add(0, 1, 0, 12'h022, 12'h022, 2, 0);
    add(0, 1, 0, 12'h033, 12'h033, 3, 0);
    add(0, 0, 1, 12'h000, 12'h022, 3, 0);
    add(0, 0, 1, 12'h000, 12'h011, 3, 0);
    add(0, 0, 1, 12'h000, 12'h033, 3, 0);
    add(0, 0, 0, 12'h000, 12'h033, 3, 0);
    add(1, 1, 1, 12'h0ff, 12'h000, 0, 0);
    add(0, 0, 1, 12'h000, 12'h000, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 0, 12'(k), 12'(k), k, 0);
    add(0, 1, 0, 12'h006, 12'h006, 5, 1);
    add(0, 0, 1, 12'h000, 12'h005, 5, 0);
    add(0, 0, 1, 12'h000, 12'h004, 5, 0);
    add(0, 0, 1, 12'h000, 12'h003, 5, 0);
    add(0, 0, 1, 12'h000, 12'h002, 5, 0);
    add(0, 0, 1, 12'h000, 12'h006, 5, 0);
    add(0, 1, 0, 12'h007, 12'h007, 5, 1);
    add(0, 1, 0, 12'h008, 12'h008, 5, 1);
    add(0, 0, 1, 12'h000, 12'h007, 5, 0);
    add(0, 0, 0, 12'h000, 12'h007, 5, 0);
    add(1, 0, 0, 12'h000, 12'h000, 0, 0);
    add(0, 1, 0, 12'h0aa, 12'h0aa, 1, 0);
    add(0, 1, 0, 12'h0bb, 12'h0bb, 2, 0);
    add(0, 1, 1, 12'h0cc, 12'h0cc, 3, 0);
    add(0, 0, 1, 12'h000, 12'h0bb, 3, 0);
    add(1, 0, 0, 12'h000, 12'h000, 0, 0);
    add(0, 1, 0, 12'h123, 12'h123, 1, 0);
    add(0, 0, 1, 12'h000, 12'h123, 1, 0);

    #2;
    chk_a("reset", 12'h000, 0, 0);
    chk_b("reset", 12'h000, 0, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < n_vec; i++) begin
      step_a(tbl[i].clr, tbl[i].psh, tbl[i].prv, tbl[i].din);
      chk_a($sformatf("vec%0d", i), tbl[i].eout, tbl[i].elvl, tbl[i].eovf);
    end

    // Reject-when-full instance: sixth push is dropped, browsing reaches the original oldest.
    for (int k = 1; k <= 5; k++) begin
      step_b(1, 0, 12'(k));
      chk_b($sformatf("b_push%0d", k), 12'(k), k, 0);
    end
    step_b(1, 0, 12'h006);
    chk_b("b_push6", 12'h005, 5, 1);
    for (int k = 4; k >= 1; k--) begin
      step_b(0, 1, 12'h000);
      chk_b($sformatf("b_prev_to%0d", k), 12'(k), 5, 0);
    end
    step_b(0, 1, 12'h000);
    chk_b("b_prev_wrap", 12'h005, 5, 0);

`ifdef HISTORY_BUF_NEXT_EN
    step_a(1, 0, 0, 12'h000);
    step_a(0, 1, 0, 12'h011);
    step_a(0, 1, 0, 12'h022);
    step_a(0, 1, 0, 12'h033);
    step_a(0, 0, 1, 12'h000);
    step_a(0, 0, 1, 12'h000);
    step_a(0, 0, 1, 12'h000);
    chk_a("n_prev3", 12'h033, 3, 0);
    a_next = 1; @(posedge clk); #1; a_next = 0;
    chk_a("n_next_wrap", 12'h011, 3, 0);
    a_next = 1; @(posedge clk); #1; a_next = 0;
    chk_a("n_next", 12'h022, 3, 0);
    a_next = 1; a_prev = 1; @(posedge clk); #1; a_next = 0; a_prev = 0;
    chk_a("n_both", 12'h022, 3, 0);
`endif

    // Fill, raise clear, then pulse rst between edges: state must drop immediately.
    step_a(1, 0, 0, 12'h000);
    for (int k = 1; k <= 5; k++) step_a(0, 1, 0, 12'(16 * k));
    chk_a("rst_pre", 12'h050, 5, 0);
    a_clear = 1;
    #2 rst = 1;
    #1;
    chk_a("rst_async", 12'h000, 0, 0);
    rst = 0;
    a_clear = 0;
    step_a(0, 0, 1, 12'h000);
    chk_a("rst_browse", 12'h000, 0, 0);
    step_a(0, 1, 0, 12'h077);
    chk_a("rst_push", 12'h077, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
